// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles the two buses of the instruction fetch stage: the CPU-facing
// instruction port and the byte-wide program ROM port.
//
//   cpu_pc       CPU program counter (address of the wanted instruction)
//   instr_ready  CPU takes the presented instruction when instr_valid=1
//   instr_valid  opcode1/opcode2 hold the full instruction at cpu_pc
//   opcode1      instruction byte 0 (ROM[buf_addr])
//   opcode2      instruction byte 1 (ROM[buf_addr+1])
//   mem_req      ROM read request; mem_addr is stable while it is high
//   mem_addr     ROM byte address
//   mem_ack      ROM data valid on mem_rdata (same-cycle ack allowed)
//   mem_rdata    ROM read data
//   fetch_err    sticky ROM timeout fault
//   fetch_count  completed instruction-word fetches, wraps at 8 bits
//
// Modports:
//   master  the fetch unit itself
//   slave   the environment around it (CPU + ROM)
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if;
    logic [7:0] cpu_pc;
    logic       instr_ready;
    logic       instr_valid;
    logic [7:0] opcode1;
    logic [7:0] opcode2;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       fetch_err;
    logic [7:0] fetch_count;

    modport master (
        input  cpu_pc,
        input  instr_ready,
        input  mem_ack,
        input  mem_rdata,
        output instr_valid,
        output opcode1,
        output opcode2,
        output mem_req,
        output mem_addr,
        output fetch_err,
        output fetch_count
    );

    modport slave (
        output cpu_pc,
        output instr_ready,
        output mem_ack,
        output mem_rdata,
        input  instr_valid,
        input  opcode1,
        input  opcode2,
        input  mem_req,
        input  mem_addr,
        input  fetch_err,
        input  fetch_count
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage in front of the 8-bit CPU. Reads a two-byte instruction
// (opcode1 at PC, opcode2 at PC+1) from a variable-latency, byte-wide ROM
// through a req/ack handshake and presents it to the CPU with a valid flag.
// With PREFETCH_EN=1 the word following the consumed one is fetched
// immediately, hiding ROM latency on straight-line code.
//
// Parameters:
//   PREFETCH_EN  1: fetch buf_addr+2 as soon as the held word is consumed
//                0: fetch only on demand (at cpu_pc)
//   MAX_WAIT     cycles a byte request may wait for mem_ack before fault
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   reset  asynchronous, active-low reset
//   bus    instr_fetch_unit_if.master (CPU port + ROM port)
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter bit          PREFETCH_EN = 1'b1,
    parameter int unsigned MAX_WAIT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_fetch_unit_if.master    bus
);

    // IDLE : one cycle after reset, then start fetching at cpu_pc
    // F0   : fetching byte 0 at fetch_addr
    // F1   : fetching byte 1 at fetch_addr+1
    // HOLD : word buffered, waiting for the CPU to take it or branch away
    // ERR  : ROM timed out; only reset leaves this state
    typedef enum logic [2:0] {
        IDLE,
        F0,
        F1,
        HOLD,
        ERR
    } state_t;

    // The wait counter is 4 bits wide; a timeout fires on the cycle the
    // count of unanswered request cycles would reach MAX_WAIT.
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT - 1);

    state_t     state, state_d;
    logic       gap, gap_d;              // forces mem_req low for one cycle after an ack
    logic [7:0] fetch_addr, fetch_addr_d;
    logic [7:0] stage, stage_d;          // byte 0 waiting for byte 1
    logic [7:0] op1, op1_d;
    logic [7:0] op2, op2_d;
    logic [7:0] buf_addr, buf_addr_d;
    logic       buf_full, buf_full_d;
    logic [7:0] count, count_d;
    logic [3:0] wait_cnt, wait_d;

    logic       req;
    logic       ack;
    logic       timeout;
    logic       valid;
    logic [7:0] next_addr;

    assign next_addr = fetch_addr + 8'd1;

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state;
        gap_d        = 1'b0;
        fetch_addr_d = fetch_addr;
        stage_d      = stage;
        op1_d        = op1;
        op2_d        = op2;
        buf_addr_d   = buf_addr;
        buf_full_d   = buf_full;
        count_d      = count;
        wait_d       = '0;
        valid        = 1'b0;

        // A byte request is live in F0/F1 except in the return-to-zero
        // cycle that follows every ack.
        req     = ((state == F0) || (state == F1)) && !gap;
        ack     = req && bus.mem_ack;
        timeout = req && !bus.mem_ack && (wait_cnt == WAIT_LIMIT);
        if (req && !bus.mem_ack) begin
            wait_d = wait_cnt + 4'd1;
        end

        case (state)
            IDLE: begin
                fetch_addr_d = bus.cpu_pc;
                state_d      = F0;
            end

            F0: begin
                if (ack) begin
                    stage_d = bus.mem_rdata;
                    gap_d   = 1'b1;
                    state_d = F1;
                end else if (timeout) begin
                    state_d = ERR;
                end
            end

            F1: begin
                if (ack) begin
                    // A request in flight is always completed; only now do
                    // we decide whether the word is still the one wanted.
                    if (fetch_addr == bus.cpu_pc) begin
                        op1_d      = stage;
                        op2_d      = bus.mem_rdata;
                        buf_addr_d = fetch_addr;
                        buf_full_d = 1'b1;
                        count_d    = count + 8'd1;
                        state_d    = HOLD;
                    end else begin
                        fetch_addr_d = bus.cpu_pc;
                        gap_d        = 1'b1;
                        state_d      = F0;
                    end
                end else if (timeout) begin
                    state_d = ERR;
                end
            end

            HOLD: begin
                valid = buf_full && (buf_addr == bus.cpu_pc);
                if (!buf_full) begin
                    // Word was taken last cycle without prefetch: the CPU has
                    // now had a cycle to move cpu_pc, so fetch from there.
                    fetch_addr_d = bus.cpu_pc;
                    state_d      = F0;
                end else if (!valid) begin
                    // Branch: the buffered word is not at cpu_pc.
                    buf_full_d   = 1'b0;
                    fetch_addr_d = bus.cpu_pc;
                    state_d      = F0;
                end else if (bus.instr_ready) begin
                    buf_full_d = 1'b0;
                    if (PREFETCH_EN) begin
                        fetch_addr_d = buf_addr + 8'd2;
                        state_d      = F0;
                    end
                end
            end

            ERR: begin
                state_d = ERR;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            gap        <= 1'b0;
            fetch_addr <= 8'h00;
            stage      <= 8'h00;
            op1        <= 8'h00;
            op2        <= 8'h00;
            buf_addr   <= 8'h00;
            buf_full   <= 1'b0;
            count      <= 8'h00;
            wait_cnt   <= 4'h0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values computed above, independent of order.
            state      <= state_d;
            gap        <= gap_d;
            fetch_addr <= fetch_addr_d;
            stage      <= stage_d;
            op1        <= op1_d;
            op2        <= op2_d;
            buf_addr   <= buf_addr_d;
            buf_full   <= buf_full_d;
            count      <= count_d;
            wait_cnt   <= wait_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.instr_valid = valid;
    assign bus.opcode1     = op1;
    assign bus.opcode2     = op2;
    assign bus.mem_req     = req;
    assign bus.mem_addr    = (state == F1) ? next_addr : fetch_addr;
    assign bus.fetch_err   = (state == ERR);
    assign bus.fetch_count = count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit. A ROM model answers requests after a
// programmable number of wait cycles. Expected ROM addresses and expected
// consumed instructions are queued by the stimulus; two monitors pop and
// compare whenever the DUT acks a byte or hands over an instruction.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] op1;
        logic [7:0] op2;
    } instr_t;

    logic clk = 1'b0;
    logic reset;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .PREFETCH_EN (1'b1),
        .MAX_WAIT    (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    instr_t     instr_q [$];
    logic [7:0] addr_q  [$];

    // ROM model: ack after rom_lat unanswered request cycles
    logic [7:0] rom [256];
    int         rom_lat = 0;
    int         lat_cnt = 0;

    always_comb begin
        bus.mem_ack   = bus.mem_req && (lat_cnt >= rom_lat);
        bus.mem_rdata = rom[bus.mem_addr];
    end

    always @(posedge clk) begin
        if (bus.mem_req && !bus.mem_ack) lat_cnt <= lat_cnt + 1;
        else                             lat_cnt <= 0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: instructions handed to the CPU
    always @(negedge clk) begin
        instr_t e;
        if (bus.instr_valid && bus.instr_ready) begin
            if (instr_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL instr_unexpected: pc=%02h consumed, nothing expected", bus.cpu_pc);
            end else begin
                e = instr_q.pop_front();
                check("consume_pc",  32'(bus.cpu_pc),  32'(e.addr));
                check("consume_op1", 32'(bus.opcode1), 32'(e.op1));
                check("consume_op2", 32'(bus.opcode2), 32'(e.op2));
            end
        end
    end

    // Monitor: acknowledged ROM byte reads
    always @(negedge clk) begin
        logic [7:0] a;
        if (bus.mem_req && bus.mem_ack) begin
            if (addr_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL mem_unexpected: read at %02h, nothing expected", bus.mem_addr);
            end else begin
                a = addr_q.pop_front();
                check("mem_addr_seq", 32'(bus.mem_addr), 32'(a));
            end
        end
    end

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        @(negedge clk);
        while (!bus.instr_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, 32'(bus.instr_valid), 32'd1);
    endtask

    task automatic wait_req(input string name, input logic [7:0] addr, input int budget);
        int n = 0;
        @(negedge clk);
        while (!(bus.mem_req && bus.mem_addr == addr) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_req_seen"}, 32'(bus.mem_req && (bus.mem_addr == addr)), 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_valid"}, 32'(bus.instr_valid), 32'd0);
        check({name, "_op1"},   32'(bus.opcode1),     32'h00);
        check({name, "_op2"},   32'(bus.opcode2),     32'h00);
        check({name, "_req"},   32'(bus.mem_req),     32'd0);
        check({name, "_addr"},  32'(bus.mem_addr),    32'h00);
        check({name, "_err"},   32'(bus.fetch_err),   32'd0);
        check({name, "_count"}, 32'(bus.fetch_count), 32'h00);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_cycles;

        for (int i = 0; i < 256; i++) rom[i] = 8'(i);
        rom[8'h00] = 8'h1A; rom[8'h01] = 8'h55;
        rom[8'h02] = 8'hC3; rom[8'h03] = 8'h3C;
        rom[8'h04] = 8'h11; rom[8'h05] = 8'h22;
        rom[8'h10] = 8'hAB; rom[8'h11] = 8'hCD;
        rom[8'h40] = 8'hE0; rom[8'h41] = 8'h0F;
        rom[8'hFF] = 8'h99;

        reset           = 1'b0;
        bus.cpu_pc      = 8'h00;
        bus.instr_ready = 1'b0;
        rom_lat         = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");

        // T1: first fetch after reset, zero-wait ROM, valid in cycle 4
        addr_q.push_back(8'h00);
        addr_q.push_back(8'h01);
        @(posedge clk); #1 reset = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("t1_valid_c%0d", i), 32'(bus.instr_valid), 32'(i == 4));
            if (i == 1) check("t1_req_byte0", 32'({bus.mem_req, bus.mem_addr}), 32'h100);
            if (i == 2) check("t1_req_gap",   32'(bus.mem_req), 32'd0);
            if (i == 3) check("t1_req_byte1", 32'({bus.mem_req, bus.mem_addr}), 32'h101);
        end
        check("t1_op1",   32'(bus.opcode1),     32'h1A);
        check("t1_op2",   32'(bus.opcode2),     32'h55);
        check("t1_count", 32'(bus.fetch_count), 32'h01);

        // T2: sequential prefetch of 0x02/0x03 before cpu_pc moves
        @(posedge clk); #1;
        rom_lat = 2;
        instr_q.push_back('{8'h00, 8'h1A, 8'h55});
        addr_q.push_back(8'h02);
        addr_q.push_back(8'h03);
        bus.instr_ready = 1'b1;
        @(posedge clk); #1 bus.instr_ready = 1'b0;
        wait_req("t2_b1", 8'h03, 30);
        @(posedge clk); #1 bus.cpu_pc = 8'h02;
        wait_valid("t2", 30);
        check("t2_op1",     32'(bus.opcode1),     32'hC3);
        check("t2_op2",     32'(bus.opcode2),     32'h3C);
        check("t2_count",   32'(bus.fetch_count), 32'h02);
        check("t2_no_req",  32'(bus.mem_req),     32'd0);

        // T4: branch to 0x40 while prefetching 0x04
        @(posedge clk); #1;
        instr_q.push_back('{8'h02, 8'hC3, 8'h3C});
        addr_q.push_back(8'h04);
        addr_q.push_back(8'h05);
        addr_q.push_back(8'h40);
        addr_q.push_back(8'h41);
        bus.instr_ready = 1'b1;
        @(posedge clk); #1 bus.instr_ready = 1'b0;
        wait_req("t4_pf", 8'h04, 10);
        @(posedge clk); #1 bus.cpu_pc = 8'h40;
        wait_valid("t4", 60);
        check("t4_pc_at_valid", 32'(bus.cpu_pc),      32'h40);
        check("t4_op1",         32'(bus.opcode1),     32'hE0);
        check("t4_op2",         32'(bus.opcode2),     32'h0F);
        check("t4_count",       32'(bus.fetch_count), 32'h03);

        // T3: consume 0x40, jump to 0xFF; second byte wraps to 0x00
        @(posedge clk); #1;
        instr_q.push_back('{8'h40, 8'hE0, 8'h0F});
        addr_q.push_back(8'h42);
        addr_q.push_back(8'h43);
        addr_q.push_back(8'hFF);
        addr_q.push_back(8'h00);
        bus.instr_ready = 1'b1;
        @(posedge clk); #1;
        bus.instr_ready = 1'b0;
        bus.cpu_pc      = 8'hFF;
        rom_lat         = 0;
        wait_valid("t3", 30);
        check("t3_op1",   32'(bus.opcode1),     32'h99);
        check("t3_op2",   32'(bus.opcode2),     32'h1A);
        check("t3_count", 32'(bus.fetch_count), 32'h04);

        // T6: reset while byte 1 of 0x10 is being requested
        @(posedge clk); #1;
        bus.cpu_pc = 8'h10;
        rom_lat    = 3;
        addr_q.push_back(8'h10);
        wait_req("t6_b1", 8'h11, 30);
        #2 reset = 1'b0;
        #1 check_reset_outputs("t6_reset");
        addr_q.push_back(8'h10);
        addr_q.push_back(8'h11);
        rom_lat = 14;                       // longest wait that must not fault
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        wait_valid("t6", 80);
        check("t6_op1",   32'(bus.opcode1),     32'hAB);
        check("t6_op2",   32'(bus.opcode2),     32'hCD);
        check("t6_count", 32'(bus.fetch_count), 32'h01);
        check("t6_err",   32'(bus.fetch_err),   32'd0);

        // T5: ROM never answers -> fault after 15 request cycles
        @(posedge clk); #1;
        bus.cpu_pc = 8'h20;
        rom_lat    = 1000;
        req_cycles = 0;
        for (int n = 0; n < 40 && !bus.fetch_err; n++) begin
            @(negedge clk);
            if (bus.mem_req) req_cycles++;
        end
        check("t5_wait_cycles", 32'(req_cycles),   32'd15);
        check("t5_err",         32'(bus.fetch_err), 32'd1);
        @(posedge clk); #1;
        bus.cpu_pc = 8'h10;
        rom_lat    = 0;
        repeat (4) @(negedge clk);
        check("t5_err_sticky", 32'(bus.fetch_err),   32'd1);
        check("t5_req_low",    32'(bus.mem_req),     32'd0);
        check("t5_valid_low",  32'(bus.instr_valid), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("t5_err_cleared", 32'(bus.fetch_err), 32'd0);
        addr_q.push_back(8'h10);
        addr_q.push_back(8'h11);
        @(posedge clk); #1 reset = 1'b1;
        wait_valid("t5_recover", 20);
        check("t5_recover_op1", 32'(bus.opcode1), 32'hAB);
        check("t5_recover_op2", 32'(bus.opcode2), 32'hCD);

        repeat (3) @(negedge clk);
        check("instr_q_drained", 32'(instr_q.size()), 32'd0);
        check("addr_q_drained",  32'(addr_q.size()),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
